// File: rtl/clause_pkg.sv
// Shared types and width helpers for the SAT-array clause column.
package clause_pkg;

  // Widest variable index a slot record can hold; instances use the low IW bits.
  localparam int IDX_MAX = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PROG  = 2'd1,
    RUN   = 2'd2
  } clause_state_t;

  typedef struct packed {
    logic [IDX_MAX-1:0] idx;
    logic               neg;
    logic               en;
  } slot_t;

  function automatic int idx_width(input int nv);
    return (nv <= 1) ? 1 : $clog2(nv);
  endfunction

  function automatic int sel_width(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/clause_lit_mux.sv
// One literal: selects V[idx] and applies polarity; a disabled slot is never true.
module clause_lit_mux import clause_pkg::*; #(
  parameter int NV = 60
) (
  input  logic [NV-1:0]      v,
  input  logic [IDX_MAX-1:0] idx,
  input  logic               neg,
  input  logic               en,
  output logic               lit
);

  logic bit_sel;

  always_comb begin
    bit_sel = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (idx == IDX_MAX'(i)) begin
        bit_sel = v[i];
      end
    end
    lit = en & (bit_sel ^ neg);
  end

endmodule

// File: rtl/clause_column_k.sv
// K-literal clause evaluator with valid/ready programming port and registered outputs.
// Optional saturating unsatisfied-age counter enabled by `define CLAUSE_AGE_EN.
module clause_column_k import clause_pkg::*; #(
  parameter  int NV = 60,
  parameter  int K  = 3,
  parameter  int AW = 8,
  localparam int IW = idx_width(NV),
  localparam int SW = sel_width(K)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          MODE,
  input  logic [NV-1:0] V,
  input  logic          CFG_VALID,
  output logic          CFG_READY,
  input  logic [SW-1:0] CFG_SEL,
  input  logic [IW-1:0] CFG_IDX,
  input  logic          CFG_NEG,
  input  logic          CFG_EN,
  output logic          CFG_ERR,
  output logic          UNSAT,
  output logic          UNSAT_W,
  output logic          CRIT,
  output logic [IW-1:0] CRIT_IDX,
  output logic [AW-1:0] AGE,
  output logic          AGE_MAX
);

  clause_state_t state, state_nxt;
  slot_t         slots     [K];
  slot_t         slots_nxt [K];
  logic          pri, pri_nxt;
  logic [K-1:0]  lit;
  logic          wr_req, sel_lit, sel_pri, idx_ok, err_nxt, any_en;
  logic          unsat_s, crit_s;
  logic [IW-1:0] crit_idx_s;

  assign CFG_READY = (state == PROG);
  assign wr_req    = CFG_VALID & CFG_READY;
  assign sel_lit   = (CFG_SEL < SW'(K));
  assign sel_pri   = (CFG_SEL == SW'(K));
  assign idx_ok    = ({1'b0, CFG_IDX} < (IW+1)'(NV));

  // Post-write slot image; evaluation and the PROG->RUN decision both see it.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      slots_nxt[i] = slots[i];
    end
    pri_nxt = pri;
    err_nxt = 1'b0;
    if (wr_req) begin
      if (sel_lit && idx_ok) begin
        for (int i = 0; i < K; i++) begin
          if (CFG_SEL == SW'(i)) begin
            slots_nxt[i].idx = IDX_MAX'(CFG_IDX);
            slots_nxt[i].neg = CFG_NEG;
            slots_nxt[i].en  = CFG_EN;
          end
        end
      end else if (sel_pri) begin
        pri_nxt = CFG_NEG;
      end else begin
        err_nxt = 1'b1;
      end
    end
    any_en = 1'b0;
    for (int i = 0; i < K; i++) begin
      any_en = any_en | slots_nxt[i].en;
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_lit
    clause_lit_mux #(.NV(NV)) u_lit (
      .v   (V),
      .idx (slots_nxt[g].idx),
      .neg (slots_nxt[g].neg),
      .en  (slots_nxt[g].en),
      .lit (lit[g])
    );
  end

  always_comb begin
    unsat_s    = ~|lit;
    crit_s     = $onehot(lit);
    crit_idx_s = {IW{1'b0}};
    for (int i = K - 1; i >= 0; i--) begin
      if (lit[i]) begin
        crit_idx_s = slots_nxt[i].idx[IW-1:0];
      end
    end
    if (!crit_s) begin
      crit_idx_s = {IW{1'b0}};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   state_nxt = MODE ? PROG : EMPTY;
      PROG:    state_nxt = MODE ? PROG : (any_en ? RUN : EMPTY);
      RUN:     state_nxt = MODE ? PROG : RUN;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= EMPTY;
      pri   <= 1'b0;
      for (int i = 0; i < K; i++) begin
        slots[i] <= '{idx: {IDX_MAX{1'b0}}, neg: 1'b0, en: 1'b0};
      end
    end else begin
      state <= state_nxt;
      pri   <= pri_nxt;
      for (int i = 0; i < K; i++) begin
        slots[i] <= slots_nxt[i];
      end
    end
  end

  // Eval outputs hold a value only while the next state is RUN.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CFG_ERR  <= 1'b0;
      UNSAT    <= 1'b0;
      UNSAT_W  <= 1'b0;
      CRIT     <= 1'b0;
      CRIT_IDX <= {IW{1'b0}};
    end else begin
      CFG_ERR <= err_nxt;
      if (state_nxt == RUN) begin
        UNSAT    <= unsat_s;
        UNSAT_W  <= unsat_s & ~pri_nxt;
        CRIT     <= crit_s;
        CRIT_IDX <= crit_idx_s;
      end else begin
        UNSAT    <= 1'b0;
        UNSAT_W  <= 1'b0;
        CRIT     <= 1'b0;
        CRIT_IDX <= {IW{1'b0}};
      end
    end
  end

`ifdef CLAUSE_AGE_EN
  logic [AW-1:0] age_inc;

  assign age_inc = (AGE == {AW{1'b1}}) ? AGE : AGE + AW'(1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AGE     <= {AW{1'b0}};
      AGE_MAX <= 1'b0;
    end else if (state_nxt == RUN && unsat_s) begin
      AGE     <= age_inc;
      AGE_MAX <= (age_inc == {AW{1'b1}});
    end else begin
      AGE     <= {AW{1'b0}};
      AGE_MAX <= 1'b0;
    end
  end
`else
  assign AGE     = {AW{1'b0}};
  assign AGE_MAX = 1'b0;
`endif

endmodule

// File: tb/tb_clause_column_k.sv
// Directed self-checking bench for clause_column_k (NV=60, K=3, AW=4).
module tb_clause_column_k;
  localparam int NV = 60;
  localparam int K  = 3;
  localparam int AW = 4;
  localparam int IW = 6;
  localparam int SW = 2;

  logic          CLK = 1'b0;
  logic          RESET, MODE, CFG_VALID, CFG_NEG, CFG_EN;
  logic [NV-1:0] V;
  logic [SW-1:0] CFG_SEL;
  logic [IW-1:0] CFG_IDX;
  logic          CFG_READY, CFG_ERR, UNSAT, UNSAT_W, CRIT, AGE_MAX;
  logic [IW-1:0] CRIT_IDX;
  logic [AW-1:0] AGE;

  int checks = 0;
  int errors = 0;
  int age_exp;

`ifdef CLAUSE_AGE_EN
  localparam bit AGE_ON = 1'b1;
`else
  localparam bit AGE_ON = 1'b0;
`endif

  clause_column_k #(.NV(NV), .K(K), .AW(AW)) dut (
    .CLK(CLK), .RESET(RESET), .MODE(MODE), .V(V),
    .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .CFG_SEL(CFG_SEL),
    .CFG_IDX(CFG_IDX), .CFG_NEG(CFG_NEG), .CFG_EN(CFG_EN), .CFG_ERR(CFG_ERR),
    .UNSAT(UNSAT), .UNSAT_W(UNSAT_W), .CRIT(CRIT), .CRIT_IDX(CRIT_IDX),
    .AGE(AGE), .AGE_MAX(AGE_MAX)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [SW-1:0] sel, input logic [IW-1:0] idx,
                    input logic neg, input logic en);
    CFG_VALID = 1'b1; CFG_SEL = sel; CFG_IDX = idx; CFG_NEG = neg; CFG_EN = en;
    tick();
    CFG_VALID = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; MODE = 1'b1; V = '0;
    CFG_VALID = 1'b0; CFG_SEL = '0; CFG_IDX = '0; CFG_NEG = 1'b0; CFG_EN = 1'b0;
    tick(); tick();
    chk("rst_ready", CFG_READY, 0);
    chk("rst_unsat", UNSAT, 0);
    chk("rst_crit", CRIT, 0);
    chk("rst_age", AGE, 0);
    chk("rst_err", CFG_ERR, 0);
    RESET = 1'b0;
    tick();
    chk("ready_after_rst", CFG_READY, 1);

    wr(2'd0, 6'd5, 1'b0, 1'b1);
    chk("good_wr_no_err", CFG_ERR, 0);
    wr(2'd1, 6'd17, 1'b1, 1'b1);
    wr(2'd2, 6'd59, 1'b0, 1'b1);
    wr(2'd3, 6'd0, 1'b0, 1'b0);

    // Every literal false: V5=0, ~V17=0, V59=0.
    V = '0; V[17] = 1'b1; MODE = 1'b0;
    tick();
    chk("run_ready", CFG_READY, 0);
    chk("unsat", UNSAT, 1);
    chk("unsat_w", UNSAT_W, 1);
    chk("unsat_crit", CRIT, 0);
    chk("unsat_crit_idx", CRIT_IDX, 0);
    chk("age1", AGE, AGE_ON ? 1 : 0);
    tick();
    chk("age2", AGE, AGE_ON ? 2 : 0);
    tick();
    chk("age3", AGE, AGE_ON ? 3 : 0);

    V[5] = 1'b1;
    tick();
    chk("sat_unsat", UNSAT, 0);
    chk("sat_crit", CRIT, 1);
    chk("sat_crit_idx", CRIT_IDX, 5);
    chk("sat_age", AGE, 0);

    MODE = 1'b1;
    tick();
    chk("prog_unsat", UNSAT, 0);
    chk("prog_crit", CRIT, 0);
    chk("prog_ready", CFG_READY, 1);

    wr(2'd0, 6'd60, 1'b0, 1'b1);
    chk("bad_idx_err", CFG_ERR, 1);
    tick();
    chk("err_one_cycle", CFG_ERR, 0);

    MODE = 1'b0;
    tick();
    chk("slot0_kept_crit", CRIT, 1);
    chk("slot0_kept_idx", CRIT_IDX, 5);

    MODE = 1'b1;
    tick();
    wr(2'd3, 6'd0, 1'b1, 1'b0);
    V = '0; V[17] = 1'b1; MODE = 1'b0;
    tick();
    chk("pri_unsat", UNSAT, 1);
    chk("pri_unsat_w", UNSAT_W, 0);
    age_exp = 1;
    for (int i = 1; i < 20; i++) begin
      tick();
      if (age_exp < 15) age_exp++;
    end
    chk("age_sat", AGE, AGE_ON ? age_exp : 0);
    chk("age_max", AGE_MAX, AGE_ON ? 1 : 0);
    chk("pri_unsat_w_hold", UNSAT_W, 0);

    MODE = 1'b1;
    tick();
    chk("leave_age", AGE, 0);
    chk("leave_age_max", AGE_MAX, 0);

    // Clear slots; last clear coincides with MODE falling, so the block must go EMPTY.
    wr(2'd0, 6'd5, 1'b0, 1'b0);
    wr(2'd1, 6'd17, 1'b1, 1'b0);
    CFG_VALID = 1'b1; CFG_SEL = 2'd2; CFG_IDX = 6'd59; CFG_NEG = 1'b0; CFG_EN = 1'b0;
    MODE = 1'b0;
    tick();
    CFG_VALID = 1'b0;
    chk("empty_ready", CFG_READY, 0);
    chk("empty_unsat", UNSAT, 0);
    tick();
    chk("empty_stay_unsat", UNSAT, 0);
    chk("empty_stay_ready", CFG_READY, 0);

    MODE = 1'b1;
    tick();
    chk("reprog_ready", CFG_READY, 1);
    // Write on the MODE-fall edge is applied and evaluated: ~V59 with V=0 is true.
    V = '0;
    CFG_VALID = 1'b1; CFG_SEL = 2'd0; CFG_IDX = 6'd59; CFG_NEG = 1'b1; CFG_EN = 1'b1;
    MODE = 1'b0;
    tick();
    CFG_VALID = 1'b0;
    chk("fall_wr_ready", CFG_READY, 0);
    chk("fall_wr_crit", CRIT, 1);
    chk("fall_wr_crit_idx", CRIT_IDX, 59);

    MODE = 1'b1;
    tick();
    CFG_VALID = 1'b1; CFG_SEL = 2'd1; CFG_IDX = 6'd59; CFG_NEG = 1'b1; CFG_EN = 1'b1;
    MODE = 1'b0;
    tick();
    CFG_VALID = 1'b0;
    chk("dup_crit", CRIT, 0);
    chk("dup_crit_idx", CRIT_IDX, 0);
    chk("dup_unsat", UNSAT, 0);

    V[59] = 1'b1;
    tick();
    chk("dup_false_unsat", UNSAT, 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_rst_unsat", UNSAT, 0);
    chk("async_rst_unsat_w", UNSAT_W, 0);
    chk("async_rst_ready", CFG_READY, 0);
    chk("async_rst_age", AGE, 0);
    tick();
    RESET = 1'b0;
    MODE = 1'b0;
    tick();
    chk("post_rst_wait_ready", CFG_READY, 0);
    chk("post_rst_wait_unsat", UNSAT, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
